// File: rtl/dpll_pkg.sv
// Shared DPLL types and defaults used by the DCO, loop filter and phase comparator.
package dpll_pkg;

    localparam int unsigned ACC_WIDTH_DEFAULT = 32;

    typedef logic [ACC_WIDTH_DEFAULT-1:0] acc_t;

    // Edge strobe pair reported alongside each oscillator output sample.
    typedef struct packed {
        logic rising;
        logic falling;
    } strobe_t;

endpackage

// File: rtl/dco_phase_acc.sv
// Phase accumulator: adds the active FTW and an optional one-shot offset each clock.
module dco_phase_acc #(
    parameter int unsigned ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [ACC_WIDTH-1:0] ftw_active,
    input  logic [ACC_WIDTH-1:0] phase_adj,
    input  logic                 phase_adj_valid,
    output logic [ACC_WIDTH-1:0] acc,
    output logic [ACC_WIDTH-1:0] next_c,
    output logic                 wrap_c
);

    logic [ACC_WIDTH:0]   sum_c;
    logic [ACC_WIDTH-1:0] step_c;
    logic [ACC_WIDTH-1:0] adj_c;

    // Wrap is the carry of the FTW term only; the phase nudge never triggers an FTW apply.
    always_comb begin
        step_c = en ? ftw_active : '0;
        adj_c  = phase_adj_valid ? phase_adj : '0;
        sum_c  = {1'b0, acc} + {1'b0, step_c};
        wrap_c = en & sum_c[ACC_WIDTH];
        next_c = sum_c[ACC_WIDTH-1:0] + adj_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= next_c;
        end
    end

endmodule

// File: rtl/dco.sv
// Digitally controlled oscillator: FTW handshake with wrap-deferred apply, square output and edge strobes.
module dco
    import dpll_pkg::*;
#(
    parameter int unsigned          ACC_WIDTH = ACC_WIDTH_DEFAULT,
    parameter logic [ACC_WIDTH-1:0] FTW_RESET = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [ACC_WIDTH-1:0] ftw,
    input  logic                 ftw_valid,
    output logic                 ftw_ready,
    input  logic [ACC_WIDTH-1:0] phase_adj,
    input  logic                 phase_adj_valid,
    output logic                 sig_out,
    output logic                 rising,
    output logic                 falling,
    output logic                 rising_or_falling,
    output logic [ACC_WIDTH-1:0] phase
);

    localparam int unsigned MSB = ACC_WIDTH - 1;

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] next_c;
    logic                 wrap_c;
    logic [ACC_WIDTH-1:0] ftw_active;
    logic [ACC_WIDTH-1:0] ftw_pending;
    logic                 pend_flag;
    logic                 transfer_c;
    logic                 apply_c;
    strobe_t              strobe_c;
    strobe_t              strobe_q;
    logic                 any_edge_q;

    dco_phase_acc #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_phase_acc (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .ftw_active      (ftw_active),
        .phase_adj       (phase_adj),
        .phase_adj_valid (phase_adj_valid),
        .acc             (acc),
        .next_c          (next_c),
        .wrap_c          (wrap_c)
    );

    // Ready is low while pending, so a transfer and an apply are mutually exclusive.
    always_comb begin
        transfer_c = ftw_valid & ~pend_flag;
        apply_c    = pend_flag & (wrap_c | ~en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ftw_active  <= FTW_RESET;
            ftw_pending <= '0;
            pend_flag   <= 1'b0;
        end else if (transfer_c) begin
            ftw_pending <= ftw;
            pend_flag   <= 1'b1;
        end else if (apply_c) begin
            ftw_active  <= ftw_pending;
            pend_flag   <= 1'b0;
        end
    end

    // Strobes are computed from the upcoming MSB so they register in step with acc.
    always_comb begin
        strobe_c.rising  = ~acc[MSB] &  next_c[MSB];
        strobe_c.falling =  acc[MSB] & ~next_c[MSB];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q   <= '0;
            any_edge_q <= 1'b0;
        end else begin
            strobe_q   <= strobe_c;
            any_edge_q <= strobe_c.rising | strobe_c.falling;
        end
    end

    assign ftw_ready         = ~pend_flag;
    assign sig_out           = acc[MSB];
    assign rising            = strobe_q.rising;
    assign falling           = strobe_q.falling;
    assign rising_or_falling = any_edge_q;
    assign phase             = acc;

endmodule

// File: tb/tb_dco.sv
// Scoreboard bench for dco: a behavioural model queues expected outputs per driven cycle.
module tb_dco;

    localparam int unsigned AW = 32;
    localparam logic [AW-1:0] FTW_RST = 32'h4000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [AW-1:0] ftw;
    logic          ftw_valid;
    logic          ftw_ready;
    logic [AW-1:0] phase_adj;
    logic          phase_adj_valid;
    logic          sig_out;
    logic          rising;
    logic          falling;
    logic          rising_or_falling;
    logic [AW-1:0] phase;

    dco #(
        .ACC_WIDTH (AW),
        .FTW_RESET (FTW_RST)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .ftw               (ftw),
        .ftw_valid         (ftw_valid),
        .ftw_ready         (ftw_ready),
        .phase_adj         (phase_adj),
        .phase_adj_valid   (phase_adj_valid),
        .sig_out           (sig_out),
        .rising            (rising),
        .falling           (falling),
        .rising_or_falling (rising_or_falling),
        .phase             (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] phase;
        logic          sig;
        logic          rise;
        logic          fall;
        logic          ready;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] m_acc  = '0;
    logic [AW-1:0] m_act  = FTW_RST;
    logic [AW-1:0] m_pend = '0;
    logic          m_flag = 1'b0;
    logic          m_rise = 1'b0;
    logic          m_fall = 1'b0;

    task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of one clock, straight from the oscillator description.
    task automatic model(input logic r, input logic e, input logic fv, input logic [AW-1:0] f,
                         input logic pv, input logic [AW-1:0] pa);
        logic [AW:0]   sum;
        logic [AW-1:0] nxt;
        logic          wrap;
        if (r) begin
            m_acc = '0; m_act = FTW_RST; m_pend = '0; m_flag = 1'b0;
            m_rise = 1'b0; m_fall = 1'b0;
        end else begin
            sum  = {1'b0, m_acc} + {1'b0, (e ? m_act : '0)};
            wrap = e & sum[AW];
            nxt  = sum[AW-1:0] + (pv ? pa : '0);
            m_rise = ~m_acc[AW-1] & nxt[AW-1];
            m_fall = m_acc[AW-1] & ~nxt[AW-1];
            if (m_flag && (wrap || !e)) begin
                m_act = m_pend; m_flag = 1'b0;
            end else if (fv && !m_flag) begin
                m_pend = f; m_flag = 1'b1;
            end
            m_acc = nxt;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic fv, input logic [AW-1:0] f,
                        input logic pv, input logic [AW-1:0] pa);
        exp_t x;
        rst = r; en = e; ftw_valid = fv; ftw = f; phase_adj_valid = pv; phase_adj = pa;
        model(r, e, fv, f, pv, pa);
        x.phase = m_acc; x.sig = m_acc[AW-1]; x.rise = m_rise; x.fall = m_fall; x.ready = ~m_flag;
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
        x = sb.pop_front();
        chk("phase", phase, x.phase);
        chk("sig_out", 32'(sig_out), 32'(x.sig));
        chk("rising", 32'(rising), 32'(x.rise));
        chk("falling", 32'(falling), 32'(x.fall));
        chk("rise_or_fall", 32'(rising_or_falling), 32'(x.rise | x.fall));
        chk("ftw_ready", 32'(ftw_ready), 32'(x.ready));
    endtask

    task automatic idle(input int n, input logic e);
        for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, '0, 1'b0, '0);
    endtask

    logic [AW-1:0] held;

    initial begin
        rst = 1'b1; en = 1'b0; ftw = '0; ftw_valid = 1'b0; phase_adj = '0; phase_adj_valid = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("rst_phase", phase, '0);
        chk("rst_sig", 32'(sig_out), '0);
        chk("rst_ready", 32'(ftw_ready), 32'd1);

        // FTW = 2^30 from reset: period 4, rising at 2, falling at 4.
        for (int k = 1; k <= 8; k++) begin
            idle(1, 1'b1);
            chk("p4_sig", 32'(sig_out), 32'((k % 4) == 2 || (k % 4) == 3));
            chk("p4_rise", 32'(rising), 32'((k % 4) == 2));
            chk("p4_fall", 32'(falling), 32'((k % 4) == 0));
        end

        // Offer 2^29 mid-period; apply waits for the wrap, then period 8.
        idle(1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h2000_0000, 1'b0, '0);
        chk("pend_ready_low", 32'(ftw_ready), '0);
        idle(1, 1'b1);
        chk("pend_still_low", 32'(ftw_ready), '0);
        chk("pend_old_ftw", phase, 32'hC000_0000);
        idle(1, 1'b1);
        chk("apply_ready_high", 32'(ftw_ready), 32'd1);
        chk("apply_wrap_phase", phase, '0);
        for (int j = 1; j <= 8; j++) begin
            idle(1, 1'b1);
            chk("p8_sig", 32'(sig_out), 32'(j >= 4 && j <= 7));
        end

        // FTW = 2^31: toggle every clock.
        step(1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b0, '0);
        idle(10, 1'b1);
        for (int j = 0; j < 6; j++) begin
            idle(1, 1'b1);
            chk("tog_one", 32'(rising ^ falling), 32'd1);
            chk("tog_both", 32'(rising & falling), '0);
        end

        // FTW = 0 with en high: acc holds, no strobes.
        step(1'b0, 1'b1, 1'b1, '0, 1'b0, '0);
        idle(4, 1'b1);
        held = m_acc;
        for (int j = 0; j < 4; j++) begin
            idle(1, 1'b1);
            chk("ftw0_hold", phase, held);
            chk("ftw0_quiet", 32'(rising_or_falling), '0);
        end

        // Pending FTW applies on the next clock when en is low.
        step(1'b0, 1'b0, 1'b1, 32'h4000_0000, 1'b0, '0);
        idle(1, 1'b0);
        chk("en_low_apply", 32'(ftw_ready), 32'd1);
        idle(5, 1'b1);

        // en low for 10 cycles freezes everything.
        held = m_acc;
        for (int j = 0; j < 10; j++) begin
            idle(1, 1'b0);
            chk("freeze_phase", phase, held);
            chk("freeze_quiet", 32'(rising_or_falling), '0);
        end
        idle(4, 1'b1);

        // phase_adj = 2^31 from acc = 0 with en low.
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h8000_0000);
        chk("adj_phase", phase, 32'h8000_0000);
        chk("adj_sig", 32'(sig_out), 32'd1);
        chk("adj_rise", 32'(rising), 32'd1);
        for (int j = 0; j < 3; j++) begin
            idle(1, 1'b0);
            chk("adj_hold", phase, 32'h8000_0000);
            chk("adj_single", 32'(rising), '0);
        end

        // Reset while a 2^29 update is pending: it is discarded, period back to 4.
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        idle(1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h2000_0000, 1'b0, '0);
        chk("rp_pending", 32'(ftw_ready), '0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        chk("rp_phase", phase, '0);
        chk("rp_sig", 32'(sig_out), '0);
        chk("rp_ready", 32'(ftw_ready), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            idle(1, 1'b1);
            chk("rp_p4_sig", 32'(sig_out), 32'((k % 4) == 2 || (k % 4) == 3));
        end

        // Random mix of enable, FTW offers and phase nudges against the model.
        for (int j = 0; j < 80; j++) begin
            step(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                 AW'($urandom_range(0, 32'h3FFF_FFFF)), ($urandom_range(0, 7) == 0), AW'($urandom()));
            chk("rnd_excl", 32'(rising & falling), '0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
